// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a 5-stage in-order core.
// Produces per-stage write enables and bubble injects for load-use
// hazards, taken branches and data-memory waits, with a bounded memory
// wait (timeout raises a sticky error), plus a saturating stall counter.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_mem_read_i,
  input  logic             ex_br_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             id_ex_en_o,
  output logic             ex_mem_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // The wait counter only has to reach MEM_TIMEOUT-1.
  localparam int WCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] waitCnt_q, waitCnt_d;
  logic              memErr_q, memErr_d;
  logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;

  logic timeout;
  logic memStall;
  logic luHazard;

  assign timeout  = (state_q == MEM_WAIT) && (waitCnt_q == WAIT_LAST);
  assign memStall = mem_req_i && !mem_ready_i && !timeout;
  assign luHazard = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                    ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                     (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

  // Prioritised enable/flush decode; everything is held low while reset is asserted.
  always_comb begin
    pc_en_o       = 1'b0;
    if_id_en_o    = 1'b0;
    id_ex_en_o    = 1'b0;
    ex_mem_en_o   = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;
    if (!rst_ni) begin
      pc_en_o = 1'b0;
    end else if (memStall) begin
      pc_en_o = 1'b0;
    end else if (ex_br_taken_i) begin
      pc_en_o       = 1'b1;
      if_id_en_o    = 1'b1;
      id_ex_en_o    = 1'b1;
      ex_mem_en_o   = 1'b1;
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (luHazard) begin
      // Hold PC and IF/ID, push one bubble into ID/EX; the bubble clears the load next cycle.
      id_ex_en_o    = 1'b1;
      ex_mem_en_o   = 1'b1;
      id_ex_flush_o = 1'b1;
    end else begin
      pc_en_o     = 1'b1;
      if_id_en_o  = 1'b1;
      id_ex_en_o  = 1'b1;
      ex_mem_en_o = 1'b1;
    end
  end

  // Next-state logic for the memory-wait FSM, the sticky error and the stall counter.
  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    // A timeout only counts as an error if the access was still pending and not completing.
    memErr_d   = memErr_q | (timeout && mem_req_i && !mem_ready_i);
    stallCnt_d = stallCnt_q;
    if (!pc_en_o && (stallCnt_q != {CNT_W{1'b1}})) begin
      stallCnt_d = stallCnt_q + CNT_W'(1);
    end
    case (state_q)
      RUN: begin
        if (memStall) begin
          state_d   = MEM_WAIT;
          waitCnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (mem_ready_i || !mem_req_i || timeout) begin
          state_d   = RUN;
          waitCnt_d = '0;
        end else begin
          waitCnt_d = waitCnt_q + WCNT_W'(1);
        end
      end
      default: begin
        state_d   = RUN;
        waitCnt_d = '0;
      end
    endcase
  end

  // State registers; reset abandons any wait without flagging an error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      waitCnt_q  <= '0;
      memErr_q   <= 1'b0;
      stallCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      memErr_q   <= memErr_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign mem_err_o   = memErr_q;
  assign stall_cnt_o = stallCnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: table vectors, directed multi-cycle
// sequences and randomized traffic against a run-length reference model.
module tb_hazard_ctrl;

  localparam int TO = 16;
  localparam int CW = 5;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_use_rs1, id_use_rs2, ex_mem_read, ex_br_taken;
  logic          mem_req, mem_ready;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush;
  logic          mem_err;
  logic [CW-1:0] stall_cnt;
  logic [5:0]    outBus;

  // 10-unit clock.
  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_use_rs1_i  (id_use_rs1),
    .id_use_rs2_i  (id_use_rs2),
    .ex_rd_i       (ex_rd),
    .ex_mem_read_i (ex_mem_read),
    .ex_br_taken_i (ex_br_taken),
    .mem_req_i     (mem_req),
    .mem_ready_i   (mem_ready),
    .pc_en_o       (pc_en),
    .if_id_en_o    (if_id_en),
    .id_ex_en_o    (id_ex_en),
    .ex_mem_en_o   (ex_mem_en),
    .if_id_flush_o (if_id_flush),
    .id_ex_flush_o (id_ex_flush),
    .mem_err_o     (mem_err),
    .stall_cnt_o   (stall_cnt)
  );

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush}
  assign outBus = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush};

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       useRs1;
    logic       useRs2;
    logic [4:0] exRd;
    logic       exMemRead;
    logic       brTaken;
    logic       memReq;
    logic       memReady;
  } stim_t;

  typedef struct {
    string      name;
    stim_t      s;
    logic [5:0] expOut;
  } vec_t;

  localparam logic [5:0] O_NORM   = 6'b111100;
  localparam logic [5:0] O_LU     = 6'b001101;
  localparam logic [5:0] O_BR     = 6'b111111;
  localparam logic [5:0] O_FROZEN = 6'b000000;

  int checks = 0;
  int errors = 0;

  // Reference model: runLen = consecutive frozen cycles just before now.
  stim_t      cur;
  int         runLen;
  int         stalls;
  bit         errFlag;
  logic [5:0] modelOut;
  bit         modelErrNow;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    cur         = s;
    id_rs1      = s.rs1;
    id_rs2      = s.rs2;
    id_use_rs1  = s.useRs1;
    id_use_rs2  = s.useRs2;
    ex_rd       = s.exRd;
    ex_mem_read = s.exMemRead;
    ex_br_taken = s.brTaken;
    mem_req     = s.memReq;
    mem_ready   = s.memReady;
  endtask

  task automatic modelReset();
    runLen  = 0;
    stalls  = 0;
    errFlag = 0;
  endtask

  task automatic modelEval();
    bit lu, waiting, frozen;
    lu = cur.exMemRead && (cur.exRd != 0) &&
         ((cur.useRs1 && cur.rs1 == cur.exRd) || (cur.useRs2 && cur.rs2 == cur.exRd));
    waiting     = cur.memReq && !cur.memReady;
    frozen      = waiting && (runLen != TO);
    modelErrNow = waiting && (runLen == TO);
    if (frozen)           modelOut = O_FROZEN;
    else if (cur.brTaken) modelOut = O_BR;
    else if (lu)          modelOut = O_LU;
    else                  modelOut = O_NORM;
  endtask

  task automatic modelCommit();
    if (modelOut[5] == 1'b0 && stalls < CNT_MAX) stalls++;
    runLen  = (modelOut == O_FROZEN) ? runLen + 1 : 0;
    errFlag = errFlag | modelErrNow;
  endtask

  // One clock cycle: check at the falling edge, advance the model, move to posedge+1.
  task automatic runCycle(input string name, input bit useTable, input logic [5:0] tableOut);
    @(negedge clk);
    modelEval();
    checkOutput({name, ".out"}, 32'(outBus), useTable ? 32'(tableOut) : 32'(modelOut));
    checkOutput({name, ".stall_cnt"}, 32'(stall_cnt), 32'(stalls));
    checkOutput({name, ".mem_err"}, 32'(mem_err), 32'(errFlag));
    modelCommit();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset applied between edges; released just after an edge.
  task automatic doReset(input string name);
    rst_ni = 1'b0;
    #2;
    checkOutput({name, ".rst_out"}, 32'(outBus), 32'(O_FROZEN));
    checkOutput({name, ".rst_cnt"}, 32'(stall_cnt), 32'd0);
    checkOutput({name, ".rst_err"}, 32'(mem_err), 32'd0);
    modelReset();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  function automatic stim_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] rd,
                               input logic ld, input logic br, input logic rq, input logic rdy);
    stim_t s;
    s.rs1 = rs1; s.rs2 = rs2; s.useRs1 = u1; s.useRs2 = u2; s.exRd = rd;
    s.exMemRead = ld; s.brTaken = br; s.memReq = rq; s.memReady = rdy;
    return s;
  endfunction

  vec_t  vecs[$];
  stim_t idle, stallS, luS;
  int    burstLeft;

  initial begin
    idle   = mk(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    stallS = mk(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    luS    = mk(5'd9, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(idle);
    rst_ni = 1'b1;
    modelReset();
    @(posedge clk);
    #1;
    doReset("init");

    vecs.push_back('{"normal",      mk(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0), O_NORM});
    vecs.push_back('{"lu_rs1",      mk(5'd5, 5'd2, 1, 1, 5'd5, 1, 0, 0, 0), O_LU});
    vecs.push_back('{"lu_rs2",      mk(5'd9, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0), O_LU});
    vecs.push_back('{"x0_dest",     mk(5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0), O_NORM});
    vecs.push_back('{"unused_rs1",  mk(5'd7, 5'd2, 0, 1, 5'd7, 1, 0, 0, 0), O_NORM});
    vecs.push_back('{"no_load",     mk(5'd7, 5'd7, 1, 1, 5'd7, 0, 0, 0, 0), O_NORM});
    vecs.push_back('{"br_plus_lu",  mk(5'd5, 5'd2, 1, 1, 5'd5, 1, 1, 0, 0), O_BR});
    vecs.push_back('{"br_only",     mk(5'd1, 5'd2, 1, 1, 5'd3, 0, 1, 0, 0), O_BR});
    vecs.push_back('{"mem_ready",   mk(5'd1, 5'd2, 1, 1, 5'd3, 0, 0, 1, 1), O_NORM});
    vecs.push_back('{"ready_lu",    mk(5'd4, 5'd2, 1, 0, 5'd4, 1, 0, 1, 1), O_LU});
    vecs.push_back('{"ready_br",    mk(5'd4, 5'd2, 1, 0, 5'd4, 1, 1, 1, 1), O_BR});
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].s);
      runCycle(vecs[i].name, 1'b1, vecs[i].expOut);
    end

    // Load-use: one bubble, then normal flow once the load has moved on.
    doReset("lu_seq");
    applyStimulus(luS);
    runCycle("lu_seq.c1", 1'b1, O_LU);
    luS.exMemRead = 1'b0;
    applyStimulus(luS);
    runCycle("lu_seq.c2", 1'b1, O_NORM);
    checkOutput("lu_seq.stall_cnt", 32'(stall_cnt), 32'd1);

    // Memory wait of three cycles, released when ready arrives.
    doReset("mwait");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(stallS);
      runCycle("mwait.frozen", 1'b1, O_FROZEN);
    end
    stallS.memReady = 1'b1;
    applyStimulus(stallS);
    runCycle("mwait.release", 1'b1, O_NORM);
    stallS.memReady = 1'b0;
    checkOutput("mwait.stall_cnt", 32'(stall_cnt), 32'd3);
    checkOutput("mwait.mem_err", 32'(mem_err), 32'd0);

    // Timeout: 16 frozen cycles (entry plus 15 in the wait state), forced release on the next.
    doReset("tmo");
    for (int i = 0; i < TO; i++) begin
      applyStimulus(stallS);
      runCycle("tmo.frozen", 1'b1, O_FROZEN);
    end
    applyStimulus(stallS);
    runCycle("tmo.release", 1'b1, O_NORM);
    checkOutput("tmo.mem_err", 32'(mem_err), 32'd1);
    checkOutput("tmo.stall_cnt", 32'(stall_cnt), 32'(TO));
    // Keep waiting long enough to saturate the counter; error stays sticky.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(stallS);
      runCycle("tmo.more", 1'b0, 6'd0);
    end
    applyStimulus(idle);
    runCycle("tmo.idle", 1'b1, O_NORM);
    checkOutput("tmo.sat_cnt", 32'(stall_cnt), 32'(CNT_MAX));
    checkOutput("tmo.sticky", 32'(mem_err), 32'd1);

    // Ready arriving on the timeout cycle wins: release without error.
    doReset("tmo_rdy");
    for (int i = 0; i < TO; i++) begin
      applyStimulus(stallS);
      runCycle("tmo_rdy.frozen", 1'b1, O_FROZEN);
    end
    stallS.memReady = 1'b1;
    applyStimulus(stallS);
    runCycle("tmo_rdy.release", 1'b1, O_NORM);
    stallS.memReady = 1'b0;
    checkOutput("tmo_rdy.mem_err", 32'(mem_err), 32'd0);

    // Asynchronous reset in the middle of a wait, then a full fresh wait.
    doReset("arst_pre");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(stallS);
      runCycle("arst.wait", 1'b1, O_FROZEN);
    end
    #2;
    doReset("arst");
    for (int i = 0; i < TO; i++) begin
      applyStimulus(stallS);
      runCycle("arst.frozen", 1'b1, O_FROZEN);
    end
    applyStimulus(stallS);
    runCycle("arst.release", 1'b1, O_NORM);
    applyStimulus(idle);
    runCycle("arst.idle", 1'b1, O_NORM);

    // Randomized traffic with occasional long memory waits and resets.
    doReset("rnd");
    burstLeft = 0;
    for (int i = 0; i < 2000; i++) begin
      stim_t s;
      if (i % 500 == 250) doReset("rnd.rst");
      s.rs1       = 5'($urandom_range(0, 3));
      s.rs2       = 5'($urandom_range(0, 3));
      s.useRs1    = 1'($urandom_range(0, 1));
      s.useRs2    = 1'($urandom_range(0, 1));
      s.exRd      = 5'($urandom_range(0, 3));
      s.exMemRead = 1'($urandom_range(0, 1));
      s.brTaken   = ($urandom_range(0, 5) == 0);
      if (burstLeft == 0 && $urandom_range(0, 59) == 0) burstLeft = $urandom_range(10, 40);
      if (burstLeft > 0) begin
        s.memReq   = 1'b1;
        s.memReady = 1'b0;
        burstLeft--;
      end else begin
        s.memReq   = 1'($urandom_range(0, 1));
        s.memReady = ($urandom_range(0, 2) != 0);
      end
      applyStimulus(s);
      runCycle("rnd", 1'b0, 6'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
